vga_stream_capture: RTL and testbench

//  VGA sink: the receive-side counterpart of the vga_* output bundle (HS/VS/BLANK/R/G/B).

---
 rtl/vga_stream_capture.sv | 223 ++++++++++++++++++++++
 tb/tb_vga_stream_capture.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_capture.sv
// VGA receive sink: measures active geometry, locks on two identical frames and
// streams locked frames as 24-bit Avalon-ST pixels (SOP/EOP) through a FWFT FIFO.
module vga_stream_capture #(
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int CNT_W           = 12,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic             pix_en,
    input  logic             vga_HS,
    input  logic             vga_VS,
    input  logic             vga_BLANK,
    input  logic [7:0]       vga_R,
    input  logic [7:0]       vga_G,
    input  logic [7:0]       vga_B,
    output logic [23:0]      st_data,
    output logic             st_valid,
    input  logic             st_ready,
    output logic             st_sop,
    output logic             st_eop,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic             locked,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int                AW       = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [AW:0]       DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_VS, VBLANK, ACTIVE, HBLANK} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_vs_prev;
    logic [CNT_W-1:0] r_x, r_y, r_width;
    logic             r_bad;
    logic [CNT_W-1:0] r_h_active, r_v_active;
    logic             r_locked, r_overflow;
    logic             r_streaming, r_drop, r_sop_pend;
    logic             r_hold_v, r_hold_sop;
    logic [23:0]      r_hold_data;
    logic [25:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_vs_lvl, w_hs_lvl, w_vs_rise, w_hs_fault, w_in_frame;
    logic             w_frame_start, w_frame_end, w_pix, w_line_end;
    logic             w_first_line, w_line_bad, w_bad_fin, w_frame_bad, w_lock_nxt;
    logic             w_locked_next;
    logic [CNT_W-1:0] w_width_fin, w_y_inc, w_y_fin;
    logic [23:0]      w_rgb;
    logic             w_push, w_push_ok, w_ovf, w_pop, w_full;
    logic [25:0]      w_push_word, w_head;

    assign w_vs_lvl   = (SYNC_ACTIVE_LOW != 0) ? ~vga_VS : vga_VS;
    assign w_hs_lvl   = (SYNC_ACTIVE_LOW != 0) ? ~vga_HS : vga_HS;
    assign w_rgb      = {vga_R, vga_G, vga_B};
    assign w_in_frame = (r_state != WAIT_VS);

    // All frame events are qualified by pix_en so unsampled cycles leave state untouched.
    assign w_vs_rise     = pix_en & w_vs_lvl & ~r_vs_prev;
    assign w_hs_fault    = pix_en & w_hs_lvl & vga_BLANK;
    assign w_frame_start = w_vs_rise & ~w_hs_fault;
    assign w_frame_end   = w_frame_start & w_in_frame;
    assign w_pix         = pix_en & vga_BLANK & w_in_frame & ~w_vs_rise & ~w_hs_fault;
    assign w_line_end    = pix_en & ~vga_BLANK & (r_state == ACTIVE);

    assign w_first_line  = (r_y == '0);
    assign w_width_fin   = (w_line_end && w_first_line) ? r_x : r_width;
    assign w_y_inc       = (r_y == CNT_MAX) ? r_y : r_y + 1'b1;
    assign w_y_fin       = w_line_end ? w_y_inc : r_y;
    assign w_line_bad    = w_line_end && ((!w_first_line && (r_x != r_width)) || (r_y == CNT_MAX));
    assign w_bad_fin     = r_bad | w_line_bad;
    assign w_frame_bad   = w_bad_fin | vga_BLANK;
    assign w_lock_nxt    = !w_frame_bad && (w_width_fin == r_h_active) && (w_y_fin == r_v_active)
                           && (w_width_fin != '0) && (w_y_fin != '0);
    assign w_locked_next = w_frame_end ? w_lock_nxt : r_locked;

    always_comb begin
        w_state_nxt = r_state;
        if (pix_en) begin
            if (w_hs_fault) begin
                w_state_nxt = WAIT_VS;
            end else if (w_vs_rise) begin
                w_state_nxt = VBLANK;
            end else begin
                case (r_state)
                    VBLANK:  if (vga_BLANK)  w_state_nxt = ACTIVE;
                    ACTIVE:  if (!vga_BLANK) w_state_nxt = HBLANK;
                    HBLANK:  if (vga_BLANK)  w_state_nxt = ACTIVE;
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state   <= WAIT_VS;
            r_vs_prev <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (pix_en) r_vs_prev <= w_vs_lvl;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_width    <= '0;
            r_bad      <= 1'b0;
            r_h_active <= '0;
            r_v_active <= '0;
            r_locked   <= 1'b0;
        end else begin
            if (w_hs_fault || w_frame_start) begin
                r_x     <= '0;
                r_y     <= '0;
                r_width <= '0;
                r_bad   <= 1'b0;
            end else begin
                if (w_pix && r_x != CNT_MAX) r_x <= r_x + 1'b1;
                if (w_line_end) begin
                    r_x     <= '0;
                    r_y     <= w_y_fin;
                    r_width <= w_width_fin;
                end
                r_bad <= w_bad_fin | (w_pix && (r_x == CNT_MAX));
            end
            if (w_frame_end && !w_frame_bad) begin
                r_h_active <= w_width_fin;
                r_v_active <= w_y_fin;
            end
            if (w_hs_fault)       r_locked <= 1'b0;
            else if (w_frame_end) r_locked <= w_lock_nxt;
        end
    end

    // The hold register delays each pixel by one so the last one can carry EOP at frame end.
    always_comb begin
        w_push      = 1'b0;
        w_push_word = '0;
        if (w_pix && r_streaming && !r_drop && r_hold_v) begin
            w_push      = 1'b1;
            w_push_word = {r_hold_sop, 1'b0, r_hold_data};
        end else if (w_frame_end && r_hold_v) begin
            w_push      = 1'b1;
            w_push_word = {r_hold_sop, 1'b1, r_hold_data};
        end
    end

    assign st_valid  = (r_count != '0);
    assign w_pop     = st_valid & st_ready;
    assign w_full    = (r_count == DEPTH_C) & ~w_pop;
    assign w_push_ok = w_push & ~w_full;
    assign w_ovf     = w_push & w_full;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_streaming <= 1'b0;
            r_drop      <= 1'b0;
            r_sop_pend  <= 1'b0;
            r_hold_v    <= 1'b0;
            r_hold_sop  <= 1'b0;
            r_hold_data <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_hs_fault) begin
                r_streaming <= 1'b0;
                r_drop      <= 1'b0;
                r_hold_v    <= 1'b0;
            end else if (w_frame_start) begin
                r_streaming <= w_locked_next;
                r_drop      <= 1'b0;
                r_sop_pend  <= 1'b1;
                r_hold_v    <= 1'b0;
            end else if (w_pix && r_streaming && !r_drop) begin
                if (w_ovf) begin
                    r_drop   <= 1'b1;
                    r_hold_v <= 1'b0;
                end else begin
                    r_hold_v    <= 1'b1;
                    r_hold_data <= w_rgb;
                    r_hold_sop  <= r_sop_pend;
                    r_sop_pend  <= 1'b0;
                end
            end
            if (w_ovf)             r_overflow <= 1'b1;
            else if (clr_overflow) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_push_word;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head   = r_mem[r_rd_ptr];
    assign {st_sop, st_eop, st_data} = st_valid ? w_head : '0;
    assign h_active = r_h_active;
    assign v_active = r_v_active;
    assign locked   = r_locked;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_vga_stream_capture.sv
// Directed bench for vga_stream_capture: frame table plus hand-written overflow
// and mid-frame reset sequences, with an expected-beat queue on the stream side.
module tb_vga_stream_capture;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        pix_en = 1'b0;
    logic        vga_HS = 1'b1;
    logic        vga_VS = 1'b1;
    logic        vga_BLANK = 1'b0;
    logic [7:0]  vga_R = '0, vga_G = '0, vga_B = '0;
    logic [23:0] st_data;
    logic        st_valid, st_sop, st_eop;
    logic        st_ready = 1'b1;
    logic [11:0] h_active, v_active;
    logic        locked, overflow;
    logic        clr_overflow = 1'b0;

    vga_stream_capture #(.SYNC_ACTIVE_LOW(1), .CNT_W(12), .FIFO_DEPTH(16)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .pix_en(pix_en),
        .vga_HS(vga_HS), .vga_VS(vga_VS), .vga_BLANK(vga_BLANK),
        .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop), .h_active(h_active), .v_active(v_active),
        .locked(locked), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk_clk = ~clk_clk;

    int          n_checks = 0;
    int          n_err = 0;
    bit          tog = 1'b0;
    bit          ralt = 1'b0;
    logic [25:0] exp_q[$];
    logic [25:0] mon_got;

    typedef struct {
        int w; int h; int bad; bit tog; bit ralt; bit strm;
        int h_exp; int v_exp; bit lock_exp;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(st_valid), 0);
        chk({tag, "_sop"}, 32'(st_sop), 0);
        chk({tag, "_eop"}, 32'(st_eop), 0);
        chk({tag, "_data"}, 32'(st_data), 0);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_h"}, 32'(h_active), 0);
        chk({tag, "_v"}, 32'(v_active), 0);
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
        if (ralt) st_ready = ~st_ready;
    endtask

    // One sampled pixel-bus cycle; in toggle mode a pix_en=0 cycle of random junk precedes it.
    task automatic step(input logic vs_a, input logic hs_a, input logic blank, input logic [23:0] rgb);
        if (tog) begin
            pix_en = 1'b0;
            vga_VS = 1'($urandom);
            vga_HS = 1'($urandom);
            vga_BLANK = 1'($urandom);
            {vga_R, vga_G, vga_B} = 24'($urandom);
            tick();
        end
        pix_en = 1'b1;
        vga_VS = ~vs_a;
        vga_HS = ~hs_a;
        vga_BLANK = blank;
        {vga_R, vga_G, vga_B} = rgb;
        tick();
        pix_en = 1'b0;
    endtask

    task automatic vs_pulse();
        step(1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    // Frame body after a VS; queues expected beats when strm is set (max_beats>0 caps them, no EOP).
    task automatic send_frame(input int w, input int h, input int bad, input bit strm,
                              input int id, input int max_beats);
        int total;
        int lim;
        int k;
        int n;
        logic [23:0] rgb;
        total = w * h - ((bad >= 0) ? 1 : 0);
        lim = (max_beats > 0) ? max_beats : total;
        k = 0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 24'h0);
        for (int l = 0; l < h; l++) begin
            n = (l == bad) ? w - 1 : w;
            for (int x = 0; x < n; x++) begin
                rgb = {8'(id), 8'(l), 8'(x)};
                if (strm && k < lim)
                    exp_q.push_back({1'(k == 0), 1'(max_beats == 0 && k == total - 1), rgb});
                k++;
                step(1'b0, 1'b0, 1'b1, rgb);
            end
            step(1'b0, 1'b1, 1'b0, 24'h0);
            step(1'b0, 1'b0, 1'b0, 24'h0);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, "_left"}, 32'(exp_q.size()), 0);
        repeat (4) tick();
    endtask

    // A presented beat must equal the queue head (stable while stalled); popped only on ready.
    always @(negedge clk_clk) begin
        if (reset_reset_n && st_valid) begin
            mon_got = {st_sop, st_eop, st_data};
            if (exp_q.size() == 0) begin
                if (st_ready) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %h expected none", mon_got);
                end
            end else begin
                n_checks++;
                if (mon_got !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL beat: got %h expected %h", mon_got, exp_q[0]);
                end
                if (st_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        //         w  h  bad tog ralt strm h  v  lock
        vecs[0]  = '{8, 4, -1, 0, 0, 0, 8, 4, 0};
        vecs[1]  = '{8, 4, -1, 0, 0, 0, 8, 4, 1};
        vecs[2]  = '{8, 4, -1, 0, 0, 1, 8, 4, 1};
        vecs[3]  = '{8, 4,  1, 0, 0, 1, 8, 4, 0};
        vecs[4]  = '{8, 4, -1, 0, 0, 0, 8, 4, 1};
        vecs[5]  = '{6, 3, -1, 0, 0, 1, 6, 3, 0};
        vecs[6]  = '{6, 3, -1, 0, 0, 0, 6, 3, 1};
        vecs[7]  = '{6, 3, -1, 1, 0, 1, 6, 3, 1};
        vecs[8]  = '{8, 4, -1, 1, 0, 1, 8, 4, 0};
        vecs[9]  = '{8, 4, -1, 0, 1, 0, 8, 4, 1};
        vecs[10] = '{8, 4, -1, 1, 1, 1, 8, 4, 1};

        repeat (2) @(posedge clk_clk);
        #1;
        chk_zero("reset");
        reset_reset_n = 1'b1;
        repeat (3) tick();

        vs_pulse();
        for (int i = 0; i < 11; i++) begin
            tog = vecs[i].tog;
            ralt = vecs[i].ralt;
            if (!ralt) st_ready = 1'b1;
            send_frame(vecs[i].w, vecs[i].h, vecs[i].bad, vecs[i].strm, i + 1, 0);
            vs_pulse();
            chk($sformatf("row%0d_h", i), 32'(h_active), vecs[i].h_exp);
            chk($sformatf("row%0d_v", i), 32'(v_active), vecs[i].v_exp);
            chk($sformatf("row%0d_locked", i), 32'(locked), 32'(vecs[i].lock_exp));
            chk($sformatf("row%0d_ovf", i), 32'(overflow), 0);
            drain($sformatf("row%0d", i));
        end
        tog = 1'b0;
        ralt = 1'b0;

        // Overflow: a stalled locked frame fills the FIFO, the rest is dropped without EOP.
        st_ready = 1'b0;
        send_frame(8, 4, -1, 1'b1, 40, 16);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_valid", 32'(st_valid), 1);
        vs_pulse();
        chk("ovf_locked", 32'(locked), 1);
        chk("ovf_h", 32'(h_active), 8);
        st_ready = 1'b1;
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        drain("ovf_buf");
        send_frame(8, 4, -1, 1'b1, 41, 0);
        vs_pulse();
        drain("ovf_next");
        chk("ovf_after", 32'(overflow), 0);

        // Mid-line reset while stalled beats sit in the FIFO.
        st_ready = 1'b0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 24'h0);
        for (int x = 0; x < 5; x++) step(1'b0, 1'b0, 1'b1, {8'd50, 8'd0, 8'(x)});
        chk("pre_rst_valid", 32'(st_valid), 1);
        chk("pre_rst_locked", 32'(locked), 1);
        reset_reset_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        tick();
        reset_reset_n = 1'b1;
        st_ready = 1'b1;
        repeat (3) tick();

        vs_pulse();
        send_frame(8, 4, -1, 1'b0, 60, 0);
        vs_pulse();
        chk("relock_a_h", 32'(h_active), 8);
        chk("relock_a_v", 32'(v_active), 4);
        chk("relock_a_locked", 32'(locked), 0);
        send_frame(8, 4, -1, 1'b0, 61, 0);
        vs_pulse();
        chk("relock_b_locked", 32'(locked), 1);
        send_frame(8, 4, -1, 1'b1, 62, 0);
        vs_pulse();
        drain("relock_c");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
